// File: rtl/pipeline_commit_checker_if.sv
// -----------------------------------------------------------------------------
// pipeline_commit_checker_if
//   Groups every non-clock/reset signal of the commit checker.
//   master : the environment (CPU snoop points + test controller)
//   slave  : the checker itself
//
//   Control/config : start, exp_we, exp_addr, exp_data
//   Snoop          : wb_valid, wb_rd_addr, wb_data, stall, flush, halt
//   Status         : busy, done, timeout, pass, fail_count, first_fail_addr
//   Counters       : cycle_count, retire_count, stall_count, flush_count
//   Debug          : state_dbg (encoded FSM state)
//
// Handshake: the checker is a passive snoop with no backpressure. wb_valid
// qualifies wb_rd_addr/wb_data in the cycle it is high and there is no ready;
// exp_we qualifies exp_addr/exp_data the same way. start is a one-cycle pulse.
// -----------------------------------------------------------------------------
interface pipeline_commit_checker_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) ();
  logic               start;
  logic               exp_we;
  logic [RADDR_W-1:0] exp_addr;
  logic [XLEN-1:0]    exp_data;
  logic               wb_valid;
  logic [RADDR_W-1:0] wb_rd_addr;
  logic [XLEN-1:0]    wb_data;
  logic               stall;
  logic               flush;
  logic               halt;

  logic               busy;
  logic               done;
  logic               timeout;
  logic               pass;
  logic [RADDR_W:0]   fail_count;
  logic [RADDR_W-1:0] first_fail_addr;
  logic [CNT_W-1:0]   cycle_count;
  logic [CNT_W-1:0]   retire_count;
  logic [CNT_W-1:0]   stall_count;
  logic [CNT_W-1:0]   flush_count;
  logic [2:0]         state_dbg;

  modport master (
    output start, exp_we, exp_addr, exp_data,
    output wb_valid, wb_rd_addr, wb_data, stall, flush, halt,
    input  busy, done, timeout, pass, fail_count, first_fail_addr,
    input  cycle_count, retire_count, stall_count, flush_count, state_dbg
  );

  modport slave (
    input  start, exp_we, exp_addr, exp_data,
    input  wb_valid, wb_rd_addr, wb_data, stall, flush, halt,
    output busy, done, timeout, pass, fail_count, first_fail_addr,
    output cycle_count, retire_count, stall_count, flush_count, state_dbg
  );
endinterface

// File: rtl/pipeline_commit_checker.sv
// -----------------------------------------------------------------------------
// pipeline_commit_checker
//   Commit-trace checker and performance monitor for the pipelined RV32 CPU.
//   Snoops the MEM/WB writeback port plus stall/flush, keeps a shadow register
//   file, counts cycles/retirements/stalls/flushes, and after halt + drain
//   scans the shadow file against a preloaded expected table.
//
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high; returns everything to the reset state
//   bus   : pipeline_commit_checker_if.slave (see interface file for list)
//
// FSM: IDLE -> RUN -> (halt) DRAIN -> CHECK -> DONE
//                  -> (cycle limit) CHECK with timeout set
//      IDLE/DONE + start -> RUN (clears shadow, counters, results; keeps table)
// -----------------------------------------------------------------------------
module pipeline_commit_checker #(
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int RADDR_W      = 5,
  parameter int CNT_W        = 32,
  parameter int MAX_CYCLES   = 1000,
  parameter int DRAIN_CYCLES = 4
) (
  input logic                      clk,
  input logic                      reset,
  pipeline_commit_checker_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0]   MAX_C      = CNT_W'(MAX_CYCLES);
  localparam int                 DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [RADDR_W-1:0] SCAN_FIRST = RADDR_W'(1);
  localparam logic [RADDR_W-1:0] SCAN_LAST  = RADDR_W'(NUM_REGS - 1);

  state_t             state;
  logic               busy_q;
  logic               done_q;
  logic               timeout_q;
  logic               pass_q;
  logic [RADDR_W:0]   fail_q;
  logic [RADDR_W-1:0] first_q;
  logic [RADDR_W-1:0] scan_idx;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [CNT_W-1:0]   cycle_q;
  logic [CNT_W-1:0]   retire_q;
  logic [CNT_W-1:0]   stall_q;
  logic [CNT_W-1:0]   flush_q;

  logic [XLEN-1:0]     shadow    [NUM_REGS];
  logic [XLEN-1:0]     exp_table [NUM_REGS];
  logic [NUM_REGS-1:0] mask;

  logic [CNT_W-1:0]   cycle_inc;
  logic               scan_mismatch;
  logic [RADDR_W:0]   fail_next;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    cycle_inc     = sat_inc(cycle_q);
    scan_mismatch = mask[scan_idx] && (shadow[scan_idx] != exp_table[scan_idx]);
    fail_next     = fail_q + {{RADDR_W{1'b0}}, scan_mismatch};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= '0;
      first_q   <= '0;
      scan_idx  <= '0;
      drain_cnt <= '0;
      cycle_q   <= '0;
      retire_q  <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
      mask      <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i]    <= '0;
        exp_table[i] <= '0;
      end
    end else begin
      // Snooping is identical in RUN and DRAIN; DRAIN only differs in exit.
      if (state == S_RUN || state == S_DRAIN) begin
        cycle_q <= cycle_inc;
        if (bus.wb_valid) begin
          retire_q <= sat_inc(retire_q);
          // x0 is hardwired zero, so its shadow entry is never written.
          if (bus.wb_rd_addr != '0) shadow[bus.wb_rd_addr] <= bus.wb_data;
        end
        if (bus.stall) stall_q <= sat_inc(stall_q);
        if (bus.flush) flush_q <= sat_inc(flush_q);
      end

      // A new run wipes everything except the expected table and mask.
      if ((state == S_IDLE || state == S_DONE) && bus.start) begin
        state     <= S_RUN;
        busy_q    <= 1'b1;
        done_q    <= 1'b0;
        timeout_q <= 1'b0;
        pass_q    <= 1'b0;
        fail_q    <= '0;
        first_q   <= '0;
        cycle_q   <= '0;
        retire_q  <= '0;
        stall_q   <= '0;
        flush_q   <= '0;
        for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
      end

      case (state)
        S_IDLE: begin
          if (bus.exp_we && bus.exp_addr != '0) begin
            exp_table[bus.exp_addr] <= bus.exp_data;
            mask[bus.exp_addr]      <= 1'b1;
          end
        end
        S_RUN: begin
          // halt has priority, so a halt on the limit cycle is not a timeout.
          if (bus.halt) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end else if (cycle_inc == MAX_C) begin
            state     <= S_CHECK;
            timeout_q <= 1'b1;
            scan_idx  <= SCAN_FIRST;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state    <= S_CHECK;
            scan_idx <= SCAN_FIRST;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        S_CHECK: begin
          fail_q <= fail_next;
          if (scan_mismatch && fail_q == '0) first_q <= scan_idx;
          if (scan_idx == SCAN_LAST) begin
            // fail_next includes the last register scanned on this edge.
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (fail_next == '0) && !timeout_q;
          end else begin
            scan_idx <= scan_idx + RADDR_W'(1);
          end
        end
        S_DONE: begin
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.timeout         = timeout_q;
  assign bus.pass            = pass_q;
  assign bus.fail_count      = fail_q;
  assign bus.first_fail_addr = first_q;
  assign bus.cycle_count     = cycle_q;
  assign bus.retire_count    = retire_q;
  assign bus.stall_count     = stall_q;
  assign bus.flush_count     = flush_q;
  assign bus.state_dbg       = state;

endmodule

// File: tb/tb_pipeline_commit_checker.sv
// -----------------------------------------------------------------------------
// tb_pipeline_commit_checker
//   Directed bench for pipeline_commit_checker (MAX_CYCLES=20, DRAIN_CYCLES=4).
//   A table of whole runs (expected-table loads, writebacks, expected results)
//   followed by hand-written sequences for timeout, drain-time writebacks,
//   stall/flush counting, ignored inputs, mid-run reset and DONE restart.
//   Inputs are driven and outputs sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_pipeline_commit_checker;

  localparam int CHECK_LAT = 4 + 31;  // drain cycles + scan cycles after halt

  logic clk = 1'b0;
  logic reset;

  pipeline_commit_checker_if #(.XLEN(32), .RADDR_W(5), .CNT_W(32)) bus ();

  pipeline_commit_checker #(
    .XLEN(32), .NUM_REGS(32), .RADDR_W(5), .CNT_W(32),
    .MAX_CYCLES(20), .DRAIN_CYCLES(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 1'b0; bus.exp_we = 1'b0; bus.exp_addr = '0; bus.exp_data = '0;
    bus.wb_valid = 1'b0; bus.wb_rd_addr = '0; bus.wb_data = '0;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.halt = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_exp(input logic [4:0] a, input logic [31:0] d);
    bus.exp_we = 1'b1; bus.exp_addr = a; bus.exp_data = d;
    tick();
    bus.exp_we = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_valid = 1'b1; bus.wb_rd_addr = a; bus.wb_data = d;
    tick();
    bus.wb_valid = 1'b0;
  endtask

  task automatic do_halt();
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for done; lat = edges waited. With noise set, from the
  // second waited cycle on it drives a bogus x11 writeback every cycle and one
  // start pulse, all of which the checker must ignore while scanning.
  task automatic wait_done(input bit noise, output int lat);
    lat = 0;
    while (!bus.done && lat < 200) begin
      bus.wb_valid   = noise && (lat >= 1);
      bus.wb_rd_addr = 5'd11;
      bus.wb_data    = 32'd99;
      bus.start      = noise && (lat == 10);
      tick();
      lat++;
    end
    clear_inputs();
    if (!bus.done) check("done_wait_expired", 32'd0, 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0][4:0]  ea;
    logic [2:0][31:0] ev;
    int               n_wb;
    logic [2:0][4:0]  wa;
    logic [2:0][31:0] wv;
    logic             x_pass;
    logic [5:0]       x_fail;
    logic [4:0]       x_first;
    logic [31:0]      x_retire;
  } vec_t;

  function automatic vec_t mk(
    input logic [4:0] ea0, input logic [31:0] ev0,
    input logic [4:0] ea1, input logic [31:0] ev1,
    input logic [4:0] ea2, input logic [31:0] ev2,
    input int n,
    input logic [4:0] wa0, input logic [31:0] wv0,
    input logic [4:0] wa1, input logic [31:0] wv1,
    input logic [4:0] wa2, input logic [31:0] wv2,
    input logic p, input logic [5:0] f, input logic [4:0] ff, input logic [31:0] r);
    vec_t v;
    v.ea[0] = ea0; v.ev[0] = ev0; v.ea[1] = ea1; v.ev[1] = ev1; v.ea[2] = ea2; v.ev[2] = ev2;
    v.n_wb = n;
    v.wa[0] = wa0; v.wv[0] = wv0; v.wa[1] = wa1; v.wv[1] = wv1; v.wa[2] = wa2; v.wv[2] = wv2;
    v.x_pass = p; v.x_fail = f; v.x_first = ff; v.x_retire = r;
    return v;
  endfunction

  vec_t vecs[7];

  initial begin
    int lat;

    // all matching
    vecs[0] = mk(5'd1, 32'd1, 5'd2, 32'd2, 5'd4, 32'd3, 3,
                 5'd1, 32'd1, 5'd2, 32'd2, 5'd4, 32'd3, 1'b1, 6'd0, 5'd0, 32'd3);
    // single mismatch on x5
    vecs[1] = mk(5'd5, 32'd6, 5'd0, 32'd0, 5'd0, 32'd0, 1,
                 5'd5, 32'd7, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 6'd1, 5'd5, 32'd1);
    // mismatches on x3 and x12, x7 matches
    vecs[2] = mk(5'd3, 32'hA, 5'd12, 32'hB, 5'd7, 32'd7, 3,
                 5'd3, 32'hB, 5'd12, 32'hC, 5'd7, 32'd7, 1'b0, 6'd2, 5'd3, 32'd3);
    // expected write to x0 is dropped, x0 writeback still retires, x9 stays 0
    vecs[3] = mk(5'd0, 32'd5, 5'd9, 32'd0, 5'd0, 32'd0, 1,
                 5'd0, 32'd5, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 6'd0, 5'd0, 32'd1);
    // later write wins; unmasked x8 is never compared
    vecs[4] = mk(5'd6, 32'h22, 5'd0, 32'd0, 5'd0, 32'd0, 3,
                 5'd6, 32'h11, 5'd8, 32'h99, 5'd6, 32'h22, 1'b1, 6'd0, 5'd0, 32'd3);
    // later write overrides a matching one
    vecs[5] = mk(5'd6, 32'h11, 5'd0, 32'd0, 5'd0, 32'd0, 2,
                 5'd6, 32'h11, 5'd6, 32'h22, 5'd0, 32'd0, 1'b0, 6'd1, 5'd6, 32'd2);
    // top register matches, masked x30 never written
    vecs[6] = mk(5'd31, 32'hDEADBEEF, 5'd30, 32'd1, 5'd0, 32'd0, 1,
                 5'd31, 32'hDEADBEEF, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 6'd1, 5'd30, 32'd1);

    // ---------- reset state ----------
    do_reset();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_pass", bus.pass, 0);
    check("rst_fail_count", bus.fail_count, 0);
    check("rst_first_fail", bus.first_fail_addr, 0);
    check("rst_cycles", bus.cycle_count, 0);
    check("rst_state", bus.state_dbg, 0);

    // ---------- table-driven runs ----------
    for (int i = 0; i < 7; i++) begin
      do_reset();
      for (int k = 0; k < 3; k++) load_exp(vecs[i].ea[k], vecs[i].ev[k]);
      pulse_start();
      check($sformatf("v%0d_busy", i), bus.busy, 1);
      for (int j = 0; j < vecs[i].n_wb; j++) wb(vecs[i].wa[j], vecs[i].wv[j]);
      do_halt();
      wait_done(1'b0, lat);
      check($sformatf("v%0d_latency", i), lat, CHECK_LAT);
      check($sformatf("v%0d_pass", i), bus.pass, vecs[i].x_pass);
      check($sformatf("v%0d_fail_count", i), bus.fail_count, vecs[i].x_fail);
      check($sformatf("v%0d_first_fail", i), bus.first_fail_addr, vecs[i].x_first);
      check($sformatf("v%0d_retire", i), bus.retire_count, vecs[i].x_retire);
      check($sformatf("v%0d_cycles", i), bus.cycle_count, vecs[i].n_wb + 5);
      check($sformatf("v%0d_timeout", i), bus.timeout, 0);
      check($sformatf("v%0d_busy_end", i), bus.busy, 0);
    end

    // ---------- timeout, then restart from DONE clears it ----------
    do_reset();
    load_exp(5'd1, 32'd5);
    pulse_start();
    wb(5'd1, 32'd5);
    wait_done(1'b0, lat);
    check("to_latency", lat, 19 + 31);
    check("to_timeout", bus.timeout, 1);
    check("to_cycles", bus.cycle_count, 20);
    check("to_pass", bus.pass, 0);
    check("to_fail_count", bus.fail_count, 0);
    pulse_start();
    check("to_restart_timeout", bus.timeout, 0);
    check("to_restart_cycles", bus.cycle_count, 0);
    wb(5'd1, 32'd5);
    do_halt();
    wait_done(1'b0, lat);
    check("to_rerun_pass", bus.pass, 1);

    // ---------- drain writeback, x0, stall/flush, ignored inputs ----------
    do_reset();
    load_exp(5'd11, 32'd6);
    pulse_start();
    bus.wb_valid = 1'b1; bus.wb_rd_addr = 5'd0; bus.wb_data = 32'd5; bus.stall = 1'b1;
    bus.exp_we = 1'b1; bus.exp_addr = 5'd11; bus.exp_data = 32'd77;
    tick();
    clear_inputs();
    bus.stall = 1'b1; bus.flush = 1'b1;
    tick();
    clear_inputs();
    do_halt();
    tick();
    tick();
    wb(5'd11, 32'd6);
    wait_done(1'b1, lat);
    check("dr_latency", lat + 3, CHECK_LAT);
    check("dr_pass", bus.pass, 1);
    check("dr_fail_count", bus.fail_count, 0);
    check("dr_retire", bus.retire_count, 2);
    check("dr_stall", bus.stall_count, 2);
    check("dr_flush", bus.flush_count, 1);
    check("dr_cycles", bus.cycle_count, 7);

    // ---------- reset mid-RUN ----------
    do_reset();
    load_exp(5'd2, 32'd2);
    pulse_start();
    for (int j = 0; j < 7; j++) begin
      bus.wb_valid = 1'b1; bus.wb_rd_addr = 5'd2; bus.wb_data = 32'd5; bus.stall = 1'b1;
      tick();
    end
    clear_inputs();
    check("mr_cycles_before", bus.cycle_count, 7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_busy", bus.busy, 0);
    check("mr_state", bus.state_dbg, 0);
    check("mr_cycles", bus.cycle_count, 0);
    check("mr_retire", bus.retire_count, 0);
    check("mr_stall", bus.stall_count, 0);
    check("mr_flush", bus.flush_count, 0);
    check("mr_done", bus.done, 0);
    pulse_start();
    wb(5'd2, 32'd5);
    do_halt();
    wait_done(1'b0, lat);
    check("mr_mask_cleared_pass", bus.pass, 1);

    // ---------- restart from DONE keeps the expected table ----------
    do_reset();
    load_exp(5'd3, 32'd3);
    pulse_start();
    wb(5'd3, 32'd3);
    do_halt();
    wait_done(1'b0, lat);
    check("rs_first_pass", bus.pass, 1);
    load_exp(5'd3, 32'd0);  // outside IDLE, must be dropped
    pulse_start();
    check("rs_busy", bus.busy, 1);
    check("rs_done", bus.done, 0);
    check("rs_pass_cleared", bus.pass, 0);
    check("rs_retire_cleared", bus.retire_count, 0);
    check("rs_cycles_cleared", bus.cycle_count, 0);
    do_halt();
    wait_done(1'b0, lat);
    check("rs_fail_count", bus.fail_count, 1);
    check("rs_first_fail", bus.first_fail_addr, 3);
    check("rs_pass", bus.pass, 0);
    check("rs_cycles", bus.cycle_count, 5);

    // ---------- report ----------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

endmodule
